// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore main controller for the multicycle MIPS datapath. Sequences each
//   instruction through FETCH / DECODE / execute / memory / write-back states.
//   Memory accesses wait on a ready handshake. The opcode is latched in DECODE.
//   Unsupported opcodes raise a one-cycle illegal_op pulse. Retired
//   instructions are counted.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   Op                opcode from IR, sampled only in DECODE
//   mem_ready         memory ack for the current read/write access
//   PCWrite .. jump   datapath control strobes/selects (Moore, from state only)
//   illegal_op        one-cycle pulse while in TRAP
//   state             current state code (debug)
//   retired           retired-instruction count, wraps modulo 2^CNT_W
module multicycle_control_unit #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    Op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemToRead,
    output logic               MemToWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               jump,
    output logic               illegal_op,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_IMM_EXEC  = 4'd11,
        S_IMM_WB    = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b010);

    state_t          cur;
    state_t          nxt;
    logic [OP_W-1:0] op_q;
    logic            retire;

    assign state = cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            op_q    <= '0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                op_q <= Op;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // IRWrite/PCWrite stay asserted for all of FETCH; the datapath qualifies
    // them with mem_ready so the IR and PC load only on the completing cycle.
    always_comb begin
        nxt         = S_IDLE;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemToRead   = 1'b0;
        MemToWrite  = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        jump        = 1'b0;
        illegal_op  = 1'b0;

        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                MemToRead = 1'b1;
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b01;
                nxt       = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_RTYPE:      nxt = S_R_EXEC;
                    OP_LW, OP_SW:  nxt = S_MEM_ADDR;
                    OP_BEQ:        nxt = S_BRANCH;
                    OP_J:          nxt = S_JUMP;
                    OP_ADDI:       nxt = S_IMM_EXEC;
                    default:       nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemToRead = 1'b1;
                IorD      = 1'b1;
                nxt       = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_MEM_WRITE: begin
                MemToWrite = 1'b1;
                IorD       = 1'b1;
                nxt        = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire     = mem_ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNC;
                nxt     = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                nxt         = S_FETCH;
                retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                jump     = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                nxt        = S_FETCH;
            end
            // Codes 14-15 fall back to IDLE with every output low.
            default: nxt = S_IDLE;
        endcase
    end

endmodule
